aes_decipher_arbiter: RTL and testbench

Shares one AES decipher core between two independent requesters. Each requester hands over a 128-bit block and a key-length flag; the arbiter grants one request at a time by round-robin and sequences the core through one block. It steers the core's round-key index to a per-requester region of an external key store. It then returns the result, or a timeout error, to the requester that owns it.

---
 rtl/aes_decipher_arbiter_if.sv | 30 +++
 rtl/aes_decipher_arbiter.sv | 148 ++++++++++++++
 tb/tb_aes_decipher_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_decipher_arbiter_if.sv
// Requester-side bus of the AES decipher arbiter.
// Two requesters share this bundle; every per-requester signal is a 2-bit
// vector indexed by requester id. Response data and error are shared.
//   req_valid/req_ready   : request handshake, one bit per requester
//   req_block0/req_block1 : ciphertext block from requester 0 / 1
//   req_keylen            : per-requester key length (0 = AES128, 1 = AES256)
//   rsp_valid/rsp_ready   : response handshake, one bit per requester
//   rsp_data/rsp_err      : shared result bus and timeout flag
// master = requester side, slave = arbiter side.
interface aes_decipher_arbiter_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_block0;
    logic [127:0] req_block1;
    logic [1:0]   req_keylen;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_block0, req_block1, req_keylen, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_block0, req_block1, req_keylen, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/aes_decipher_arbiter.sv
// Shares one AES decipher core between two requesters.
// A round-robin arbiter grants one request at a time, issues a one-cycle
// start pulse to the core, waits for the core (bounded by TIMEOUT cycles)
// and returns the result or a timeout error to the requester that owns it.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus             : requester request/response bundle (slave modport)
//   core_next       : start pulse to the core
//   core_keylen     : key length of the job in flight
//   core_block      : ciphertext of the job in flight
//   core_round      : round index requested by the core
//   core_new_block  : core result
//   core_ready      : core done pulse
//   key_addr        : key-store address {owner_id, core_round}
//   busy            : high whenever the arbiter is not idle
module aes_decipher_arbiter #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned TO_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_decipher_arbiter_if.slave bus,
    output logic                  core_next,
    output logic                  core_keylen,
    output logic [127:0]          core_block,
    input  logic [3:0]            core_round,
    input  logic [127:0]          core_new_block,
    input  logic                  core_ready,
    output logic [4:0]            key_addr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [127:0]      blk_reg;
    logic [127:0]      res_reg;
    logic              kl_reg;
    logic              owner_id;
    logic              rr_ptr;
    logic              err_reg;
    logic [TO_W-1:0]   to_cnt;

    logic              grant_any;
    logic              grant_id;
    logic              timeout_hit;

    // Two requesters: the pointer's requester wins if valid, else the other.
    always_comb begin
        grant_any = |bus.req_valid;
        grant_id  = rr_ptr ? bus.req_valid[1] : ~bus.req_valid[0];
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        core_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    // Gated by rst_n so no grant is offered while reset is held.
                    bus.req_ready[grant_id] = rst_n;
                    state_next              = ISSUE;
                end
            end
            ISSUE: begin
                core_next  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[owner_id] = 1'b1;
                if (bus.rsp_ready[owner_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_reg  <= '0;
            res_reg  <= '0;
            kl_reg   <= 1'b0;
            owner_id <= 1'b0;
            rr_ptr   <= 1'b0;
            err_reg  <= 1'b0;
            to_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        blk_reg  <= grant_id ? bus.req_block1 : bus.req_block0;
                        kl_reg   <= bus.req_keylen[grant_id];
                        owner_id <= grant_id;
                        rr_ptr   <= ~grant_id;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                end
                WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // A completion in the timeout cycle still counts as success.
                    if (core_ready) begin
                        res_reg <= core_new_block;
                        err_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        res_reg <= '0;
                        err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_data = (state == RESP) ? res_reg : '0;
    assign bus.rsp_err  = (state == RESP) ? err_reg : 1'b0;
    assign core_block   = blk_reg;
    assign core_keylen  = kl_reg;
    assign key_addr     = {owner_id, core_round};
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// Self-checking bench for aes_decipher_arbiter: a vector table of jobs,
// hand-written backpressure and reset-mid-job sequences, then randomized
// traffic checked against a transaction-level reference model.
module tb_aes_decipher_arbiter;

    localparam int TIMEOUT = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         core_next;
    logic         core_keylen;
    logic [127:0] core_block;
    logic [3:0]   core_round;
    logic [127:0] core_new_block;
    logic         core_ready;
    logic [4:0]   key_addr;
    logic         busy;

    always #5 clk = ~clk;

    aes_decipher_arbiter_if bus();

    aes_decipher_arbiter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .core_next      (core_next),
        .core_keylen    (core_keylen),
        .core_block     (core_block),
        .core_round     (core_round),
        .core_new_block (core_new_block),
        .core_ready     (core_ready),
        .key_addr       (key_addr),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- core model ----------------
    int           core_k = 0;      // latency from core_next; 0 = never answers
    logic [127:0] core_val = '0;   // fixed result when use_fn = 0
    bit           use_fn = 1'b0;
    int           stray_cnt = 0;   // bump to request one stray core_ready pulse

    function automatic logic [127:0] core_f(input logic [127:0] b, input logic kl);
        return {b[63:0], b[127:64]} ^ (kl ? {4{32'ha5a5_5a5a}} : {4{32'h3c3c_c3c3}});
    endfunction

    initial begin
        int           cnt;
        int           stray_seen;
        logic [127:0] pend;
        cnt = 0;
        stray_seen = 0;
        pend = '0;
        core_ready = 1'b0;
        core_new_block = '0;
        forever begin
            @(negedge clk);
            core_ready = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                core_ready = 1'b1;
                core_new_block = {4{32'hbadc_0ffe}};
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_ready = 1'b1;
                    core_new_block = pend;
                end
            end
            if (core_next === 1'b1) begin
                cnt = core_k;
                pend = use_fn ? core_f(core_block, core_keylen) : core_val;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
        check({tag, "_rsp_err"}, 128'(bus.rsp_err), 128'(0));
        check({tag, "_rsp_data"}, bus.rsp_data, 128'(0));
        check({tag, "_core_next"}, 128'(core_next), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_core_block"}, core_block, 128'(0));
        check({tag, "_core_keylen"}, 128'(core_keylen), 128'(0));
    endtask

    // Waits for the response (bounded), checks it, then completes the handshake.
    // Returns at posedge+1 of the cycle after the handshake.
    task automatic finish_job(input logic own, input logic [127:0] d, input logic e,
                              input int acc, input int lat);
        int n;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 100) begin
            check("job_key_owner", 128'(key_addr[4]), 128'(own));
            check("job_req_blocked", 128'(bus.req_ready), 128'(0));
            @(negedge clk);
            n++;
        end
        check("rsp_latency", 128'(cyc - acc), 128'(lat));
        check("rsp_valid", 128'(bus.rsp_valid), 128'(oh(own)));
        check("rsp_data", bus.rsp_data, d);
        check("rsp_err", 128'(bus.rsp_err), 128'(e));
        check("rsp_key_owner", 128'(key_addr[4]), 128'(own));
        bus.rsp_ready = oh(own);
        @(posedge clk);
        #1;
        bus.rsp_ready = 2'b00;
    endtask

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] blk0;
        logic [127:0] blk1;
        logic [1:0]   kl;
        int           k;
        logic [127:0] res;
        logic         grant;
        logic         err;
    } vec_t;

    vec_t tbl[10];

    // Called at posedge+1; drives the request and runs the job to completion.
    task automatic run_job(input vec_t v);
        int n;
        int acc;
        bus.req_valid  = v.valid;
        bus.req_block0 = v.blk0;
        bus.req_block1 = v.blk1;
        bus.req_keylen = v.kl;
        bus.rsp_ready  = 2'b00;
        core_k   = v.k;
        core_val = v.res;
        use_fn   = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tbl_req_ready", 128'(bus.req_ready), 128'(oh(v.grant)));
        acc = cyc;
        @(negedge clk);
        check("tbl_core_next", 128'(core_next), 128'(1));
        check("tbl_core_block", core_block, v.grant ? v.blk1 : v.blk0);
        check("tbl_core_keylen", 128'(core_keylen), 128'(v.kl[v.grant]));
        finish_job(v.grant, v.err ? 128'(0) : v.res, v.err, acc,
                   v.err ? TIMEOUT + 2 : v.k + 2);
    endtask

    // ---------------- reference model state (random phase) ----------------
    bit           m_busy;
    logic         m_rr;
    logic         m_owner;
    logic         m_kl;
    logic         m_err;
    logic [127:0] m_blk;
    logic [127:0] m_data;
    int           m_acc;
    int           m_due;

    initial begin
        int   acc;
        int   n;
        int   sel;
        int   g;
        bit   found;
        bit   rsp_on;

        tbl[0] = '{2'b11, {4{32'h0bad_0001}}, {4{32'h0bad_0002}}, 2'b10, 7,  {4{32'hc0de_0000}}, 1'b0, 1'b0};
        tbl[1] = '{2'b11, {4{32'h1bad_0001}}, {4{32'h1bad_0002}}, 2'b01, 9,  {4{32'hc0de_0001}}, 1'b1, 1'b0};
        tbl[2] = '{2'b11, {4{32'h2bad_0001}}, {4{32'h2bad_0002}}, 2'b11, 3,  {4{32'hc0de_0002}}, 1'b0, 1'b0};
        tbl[3] = '{2'b11, {4{32'h3bad_0001}}, {4{32'h3bad_0002}}, 2'b00, 5,  {4{32'hc0de_0003}}, 1'b1, 1'b0};
        tbl[4] = '{2'b01, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, {4{32'h4bad_0002}}, 2'b00, 12,
                   128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0};
        tbl[5] = '{2'b01, {4{32'h5bad_0001}}, {4{32'h5bad_0002}}, 2'b01, 5,  {4{32'hc0de_0005}}, 1'b0, 1'b0};
        tbl[6] = '{2'b10, {4{32'h6bad_0001}}, {4{32'h6bad_0002}}, 2'b10, 40, {4{32'hc0de_0006}}, 1'b1, 1'b1};
        tbl[7] = '{2'b10, {4{32'h7bad_0001}}, {4{32'h7bad_0002}}, 2'b00, 3,  {4{32'hc0de_0007}}, 1'b1, 1'b0};
        tbl[8] = '{2'b01, {4{32'h8bad_0001}}, {4{32'h8bad_0002}}, 2'b01, 32, {4{32'hc0de_0008}}, 1'b0, 1'b0};
        tbl[9] = '{2'b11, {4{32'h9bad_0001}}, {4{32'h9bad_0002}}, 2'b10, 1,  {4{32'hc0de_0009}}, 1'b1, 1'b0};

        bus.req_valid  = 2'b11;
        bus.req_block0 = {4{32'hffff_0000}};
        bus.req_block1 = {4{32'h0000_ffff}};
        bus.req_keylen = 2'b11;
        bus.rsp_ready  = 2'b11;
        core_round     = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_req_ready", 128'(bus.req_ready), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: contention, single job, timeout, tie, min latency
        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i]);
        end

        // Backpressure: response held for 20 cycles with the other requester waiting
        bus.req_valid  = 2'b01;
        bus.req_block0 = {4{32'hb10c_0000}};
        bus.req_keylen = 2'b00;
        core_k   = 4;
        core_val = {4{32'h5eed_1234}};
        @(negedge clk);
        check("bp_req_ready", 128'(bus.req_ready), 128'(2'b01));
        acc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 128'(cyc - acc), 128'(6));
        for (int i = 0; i < 20; i++) begin
            check("bp_rsp_valid", 128'(bus.rsp_valid), 128'(2'b01));
            check("bp_rsp_data", bus.rsp_data, {4{32'h5eed_1234}});
            check("bp_rsp_err", 128'(bus.rsp_err), 128'(0));
            check("bp_req_ready", 128'(bus.req_ready), 128'(0));
            bus.rsp_ready = 2'b10;
            if (i == 5) stray_cnt++;
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        check("bp_next_grant", 128'(bus.req_ready), 128'(2'b10));
        acc = cyc;
        core_k   = 3;
        core_val = {4{32'h0ddb_a11a}};
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        finish_job(1'b1, {4{32'h0ddb_a11a}}, 1'b0, acc, 5);

        // Reset in the middle of WAIT
        bus.req_valid = 2'b01;
        core_k   = 12;
        core_val = {4{32'hdead_dead}};
        @(negedge clk);
        check("rst_req_ready", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("rst_core_next", 128'(core_next), 128'(1));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < 15; i++) begin
            check("midrst_no_rsp", 128'(bus.rsp_valid), 128'(0));
            check("midrst_idle", 128'(busy), 128'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        core_k   = 2;
        core_val = {4{32'h600d_f00d}};
        @(negedge clk);
        check("midrst_rr_reset", 128'(bus.req_ready), 128'(2'b01));
        acc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        finish_job(1'b0, {4{32'h600d_f00d}}, 1'b0, acc, 4);

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        use_fn  = 1'b1;
        m_busy  = 1'b0;
        m_rr    = 1'b0;
        m_owner = 1'b0;
        m_acc   = -10;
        m_due   = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid  = 2'($urandom);
            bus.req_block0 = {$urandom, $urandom, $urandom, $urandom};
            bus.req_block1 = {$urandom, $urandom, $urandom, $urandom};
            bus.req_keylen = 2'($urandom);
            bus.rsp_ready  = 2'($urandom);
            core_round     = 4'($urandom);
            if (!m_busy) begin
                sel = int'($urandom_range(0, 9));
                core_k = (sel < 7) ? int'($urandom_range(1, 12)) :
                         (sel == 7) ? TIMEOUT : (sel == 8) ? TIMEOUT + 1 : TIMEOUT + 13;
            end
            @(negedge clk);
            found = 1'b0;
            g = 0;
            for (int j = 0; j < 2; j++) begin
                if (!found && bus.req_valid[(int'(m_rr) + j) % 2]) begin
                    g = (int'(m_rr) + j) % 2;
                    found = 1'b1;
                end
            end
            rsp_on = m_busy && (cyc >= m_due);
            check("rnd_req_ready", 128'(bus.req_ready),
                  128'((!m_busy && found) ? oh(g[0]) : 2'b00));
            check("rnd_busy", 128'(busy), 128'(m_busy));
            check("rnd_core_next", 128'(core_next), 128'(m_busy && (cyc == m_acc + 1)));
            check("rnd_key_addr", 128'(key_addr), 128'({m_owner, core_round}));
            check("rnd_rsp_valid", 128'(bus.rsp_valid), 128'(rsp_on ? oh(m_owner) : 2'b00));
            if (rsp_on) begin
                check("rnd_rsp_data", bus.rsp_data, m_data);
                check("rnd_rsp_err", 128'(bus.rsp_err), 128'(m_err));
            end
            if (m_busy) begin
                check("rnd_core_block", core_block, m_blk);
                check("rnd_core_keylen", 128'(core_keylen), 128'(m_kl));
                if (rsp_on && bus.rsp_ready[m_owner]) m_busy = 1'b0;
            end else if (found) begin
                m_busy  = 1'b1;
                m_owner = g[0];
                m_rr    = ~g[0];
                m_acc   = cyc;
                m_blk   = g[0] ? bus.req_block1 : bus.req_block0;
                m_kl    = bus.req_keylen[g];
                m_err   = (core_k > TIMEOUT);
                m_due   = cyc + (m_err ? TIMEOUT + 2 : core_k + 2);
                m_data  = m_err ? 128'(0) : core_f(m_blk, m_kl);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
